part_buf_packer: RTL
====================

Name: part_buf_packer

Overview:
- Assembles a stream of narrow parts into full-width words.
- Part width is DATA_W / PARTS, the same size-division rule the part buffer uses.
- Sits directly upstream of the part-buffer consumer: it accepts PART_W-bit parts with valid/ready and presents packed DATA_W-bit words with valid/ready.
- Supports early termination (in_last), which emits a zero-padded partial word tagged with its part count.

Parameters:
- DATA_W, 24, packed output word width in bits.
- PARTS, 8, number of parts per word. DATA_W % PARTS must be 0; elaboration error otherwise.
- PART_W (localparam), DATA_W/PARTS, part width (3 at defaults).
- CNT_W (localparam), $clog2(PARTS+1), width of the part counter and of out_parts.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  part offered.
- in_ready  output  1  packer can accept a part this cycle.
- in_data  input  PART_W  part payload.
- in_last  input  1  qualifies in_data: this part ends the current word.
- out_valid  output  1  packed word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W  packed word; part 0 in bits [PART_W-1:0].
- out_parts  output  CNT_W  number of valid parts in out_data (1..PARTS).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: out_valid=0, out_data=0, out_parts=0, internal acc=0, cnt=0. in_ready is high in the first cycle after reset.
- rst asserted mid-word discards all accumulated parts and any pending output word. rst has priority over every handshake in the same cycle.
- Input acceptance: a part is accepted when in_valid && in_ready at a rising edge.
- Placement: an accepted part is written to acc[cnt*PART_W +: PART_W].
- Completion: a word completes when the accepted part has cnt==PARTS-1 or in_last=1.
- Non-completing accept: cnt <= cnt+1.
- Completing accept, next cycle:
  - out_data = acc with the new part merged in; parts above the last are zero.
  - out_parts = cnt+1.
  - out_valid = 1.
  - acc and cnt are cleared to 0.
- Latency: out_valid rises 1 cycle after the completing part is accepted. A word is never combinationally bypassed.
- in_ready is low only when the next part would complete a word while the output register is occupied and not draining:
  in_ready = !( (cnt==PARTS-1 || in_last) && out_valid && !out_ready ).
  - Non-completing parts are always accepted, even while out_valid is held.
  - in_ready may depend combinationally on in_last and out_ready. The input source must not make in_valid depend on in_ready.
- Output handshake: a word is transferred when out_valid && out_ready.
  - If no new word completes in the same cycle, out_valid <= 0.
  - out_data and out_parts keep their last value after transfer (they are not cleared).
- Simultaneous drain and complete: the new word loads in the same edge and out_valid stays 1. This gives full throughput of one word per PARTS cycles with no bubble.
- Output stability: while out_valid=1 && out_ready=0, out_data and out_parts must not change.
- Counter wrap: cnt never exceeds PARTS-1 and returns to 0 only through completion or reset.
- in_last on the PARTS-th part behaves the same as a natural full word (out_parts=PARTS).
- in_data and in_last are ignored when in_valid=0.

Test Plan (DATA_W=24, PARTS=8):
- Full word: parts 0,1,...,7 back-to-back, out_ready=1 -> one cycle after the 8th accept, out_valid=1, out_data=0xFAC688, out_parts=8; in_ready stays 1 throughout.
- Partial word: three parts of 7, in_last on the third -> out_data=0x0001FF, out_parts=3; the next word starts at bit 0.
- Backpressure: hold out_ready=0 after word A=0xFFFFFF emits, then stream 8 more parts of 1:
  - 7 parts are accepted.
  - On the 8th, in_ready=0 and A stays stable.
  - Raise out_ready -> the 8th part is accepted the same cycle; next cycle out_data=0x249249, out_valid=1.
- Streaming throughput: 4 consecutive full words with out_ready=1 -> out_valid pulses every 8 cycles with no dropped part and in_ready constantly 1.
- Reset mid-word: 4 parts of 7 accepted, assert rst for 1 cycle -> out_valid=0 and cnt=0. Then 8 parts of 0 -> out_data=0x000000, out_parts=8 (no residue from before reset).
- Reset with pending output: out_valid=1 held under out_ready=0, assert rst -> out_valid=0 next cycle and in_ready=1.

Source files
------------

// File: rtl/part_buf_packer.sv
// part_buf_packer
//   Packs a stream of PART_W-bit parts into DATA_W-bit words. A word is
//   emitted after PARTS parts, or earlier when a part arrives with in_last.
//   A partial word is zero-padded above its last part and tagged with its
//   part count. Each completed word is registered, so there is no
//   combinational path from input to output data.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over handshakes)
//   in_valid   part offered
//   in_ready   packer can take the offered part this cycle
//   in_data    part payload (PART_W bits)
//   in_last    offered part closes the current word
//   out_valid  packed word available
//   out_ready  consumer takes the word
//   out_data   packed word, part 0 in bits [PART_W-1:0]
//   out_parts  number of valid parts in out_data (1..PARTS)
module part_buf_packer #(
  parameter  int unsigned DATA_W = 24,
  parameter  int unsigned PARTS  = 8,
  localparam int unsigned PART_W = DATA_W / PARTS,
  localparam int unsigned CNT_W  = $clog2(PARTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PART_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_parts
);

  generate
    if (DATA_W % PARTS != 0) begin : g_bad_parts
      $error("part_buf_packer: DATA_W must be a multiple of PARTS");
    end
  endgenerate

  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              closes;
  logic              accept;
  logic              complete;
  logic [DATA_W-1:0] merged;

  // The offered part would finish the word in progress.
  assign closes   = (cnt == CNT_W'(PARTS - 1)) || in_last;

  // Only a completing part needs the output register; anything else
  // just goes into the accumulator.
  assign in_ready = !(closes && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && closes;

  // acc is zero above the parts already placed, so OR-ing the new part
  // in at its slot leaves everything above it zero.
  always_comb begin
    merged = acc | (DATA_W'(in_data) << (32'(cnt) * PART_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_parts <= '0;
    end else begin
      if (accept) begin
        if (closes) begin
          out_data  <= merged;
          out_parts <= cnt + CNT_W'(1);
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= merged;
          cnt <= cnt + CNT_W'(1);
        end
      end
      // A word loaded on the same edge as a drain keeps out_valid high.
      if (complete) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
